// File: rtl/cnn_pxl_feeder.sv
// cnn_pxl_feeder
// Producer end of the conv layer-1 pixel interface. Packed 3-channel pixels
// are buffered in a small FIFO. After a start pulse, and once enough pixels
// are queued, one frame is streamed in raster order as three 8-bit channel
// pixels per clock. The block also drives the conv pipeline reset.
//
// Optional feature: define CNN_FEED_PAD_EN to wrap the frame in a one-pixel
// zero border. The output frame is then (IMG_W+2) x (IMG_H+2), and border
// positions never pop the FIFO.

module cnn_pxl_feeder #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int FIFO_DEPTH = 16,
    parameter int START_LVL  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic [7:0]  pxl_0,
    output logic [7:0]  pxl_1,
    output logic [7:0]  pxl_2,
    output logic        pxl_valid,
    output logic        sof,
    output logic        eof,
    output logic        conv_reset,
    output logic        busy,
    output logic        underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef CNN_FEED_PAD_EN
    localparam int OW = IMG_W + 2;
    localparam int OH = IMG_H + 2;
`else
    localparam int OW = IMG_W;
    localparam int OH = IMG_H;
`endif

    localparam int CW = $clog2(OW);
    localparam int RW = $clog2(OH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic [23:0]   rd_data;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          stream_issue;
    logic          data_pos;
    logic          first_pos;
    logic          last_pos;
    logic          col_last;
    logic          row_last;

    // Pointers carry one extra wrap bit, so their difference is the exact
    // fill level, including the full case.
    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign rd_data    = fifo_mem[rd_ptr[AW-1:0]];
    assign push       = in_valid & in_ready;
    assign level_next = level + (AW+1)'(push) - (AW+1)'(pop);

    // A position is issued in every STREAM cycle except the one in which eof
    // is on the outputs. That extra cycle keeps busy high while eof is shown.
    assign stream_issue = (state == ST_STREAM) && !eof;

    assign col_last  = (col == CW'(OW - 1));
    assign row_last  = (row == RW'(OH - 1));
    assign first_pos = (col == '0) && (row == '0);
    assign last_pos  = col_last && row_last;

`ifdef CNN_FEED_PAD_EN
    assign data_pos = !((row == '0) || row_last || (col == '0) || col_last);
`else
    assign data_pos = 1'b1;
`endif

    assign pop  = stream_issue && data_pos && !fifo_empty;
    assign busy = (state != ST_IDLE);

    // FIFO storage. It needs no reset, because flushing moves only the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointers and the registered ready. Ready is computed from the level
    // after this cycle's push/pop, so a push can never land on a full FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            in_ready <= (level_next != (AW+1)'(FIFO_DEPTH));
        end
    end

    // Frame sequencing: wait for start, wait for enough data, then stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (level >= (AW+1)'(START_LVL)) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (eof) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Raster position counters. They are cleared while filling, and they advance
    // on every issued position whether or not data was available.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (state == ST_FILL) begin
            col <= '0;
            row <= '0;
        end else if (stream_issue) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Registered pixel outputs and frame markers. Border and starved positions
    // emit zeros but still count as valid frame pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_0      <= '0;
            pxl_1      <= '0;
            pxl_2      <= '0;
            pxl_valid  <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            conv_reset <= 1'b1;
        end else if (stream_issue) begin
            pxl_0      <= pop ? rd_data[7:0]   : 8'd0;
            pxl_1      <= pop ? rd_data[15:8]  : 8'd0;
            pxl_2      <= pop ? rd_data[23:16] : 8'd0;
            pxl_valid  <= 1'b1;
            sof        <= first_pos;
            eof        <= last_pos;
            conv_reset <= 1'b0;
        end else begin
            pxl_0      <= '0;
            pxl_1      <= '0;
            pxl_2      <= '0;
            pxl_valid  <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            conv_reset <= 1'b1;
        end
    end

    // Sticky starvation flag. It is cleared only by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            underrun <= 1'b0;
        end else if (stream_issue && data_pos && fifo_empty) begin
            underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_pxl_feeder.sv
// Testbench for cnn_pxl_feeder (4x3 frame, 16-entry FIFO, start level 4).
// The expected frame is built from a queue of accepted pixels and the raster
// and border rules, so the padded build (CNN_FEED_PAD_EN) is covered too.

module tb_cnn_pxl_feeder;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 3;
    localparam int FIFO_DEPTH = 16;
    localparam int START_LVL  = 4;

`ifdef CNN_FEED_PAD_EN
    localparam bit PAD = 1'b1;
    localparam int OW  = IMG_W + 2;
    localparam int OH  = IMG_H + 2;
`else
    localparam bit PAD = 1'b0;
    localparam int OW  = IMG_W;
    localparam int OH  = IMG_H;
`endif
    localparam int FRAME_LEN = OW * OH;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic [7:0]  pxl_0, pxl_1, pxl_2;
    logic        pxl_valid, sof, eof, conv_reset, busy, underrun;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] model_q [$];
    int          pix_n = 0;
    logic        ready_before_sof;
    logic        ready_at_sof;

    typedef struct {
        int preload;
        bit pattern;
        bit mid_start;
        bit exp_underrun;
    } vec_t;

    vec_t tbl [5];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    cnn_pxl_feeder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH), .START_LVL(START_LVL)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .pxl_0(pxl_0), .pxl_1(pxl_1),
        .pxl_2(pxl_2), .pxl_valid(pxl_valid), .sof(sof), .eof(eof),
        .conv_reset(conv_reset), .busy(busy), .underrun(underrun)
    );

    // Stop a hung run with a failure instead of spinning forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] next_pattern();
        logic [7:0] b;
        b = pix_n[7:0];
        pix_n++;
        return {b, b + 8'd1, b + 8'd2};
    endfunction

    // Offer one pixel until the FIFO accepts it, then record it in the model.
    task automatic apply_stimulus(input logic [23:0] data);
        logic acc;
        bit   done;
        done = 1'b0;
        in_data  = data;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            acc = in_ready;
            step();
            if (acc) begin
                model_q.push_back(data);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check_output("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic preload(input int n, input bit pattern);
        for (int k = 0; k < n; k++) begin
            if (pattern) apply_stimulus(next_pattern());
            else apply_stimulus(24'($urandom));
        end
    endtask

    // Pulse start with START_LVL already met. sof must follow two edges later.
    task automatic pulse_start(input string tag);
        int lat;
        start = 1'b1;
        step();
        start = 1'b0;
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        ready_before_sof = in_ready;
        while (lat < 64 && !pxl_valid) begin
            ready_before_sof = in_ready;
            step();
            lat++;
        end
        check_output({tag, "_latency"}, 32'(lat), 32'd2);
    endtask

    // Compare one full frame against the queue model. Border positions give
    // zero, data positions consume the queue, and an empty queue gives zero
    // and sets underrun.
    task automatic check_frame(input bit mid_start, input string tag);
        logic [23:0] data;
        logic [28:0] exp_v;
        logic [28:0] act_v;
        bit          under;
        bit          border;
        int          c, r;
        under = 1'b0;
        for (int w = 0; w < 64 && !pxl_valid; w++) step();
        ready_at_sof = in_ready;
        for (int i = 0; i < FRAME_LEN; i++) begin
            c = i % OW;
            r = i / OW;
            border = PAD && (r == 0 || r == OH - 1 || c == 0 || c == OW - 1);
            if (border) data = '0;
            else if (model_q.size() > 0) data = model_q.pop_front();
            else begin
                data  = '0;
                under = 1'b1;
            end
            exp_v = {1'b1, 1'(i == 0), 1'(i == FRAME_LEN - 1), 1'b0, under, data};
            act_v = {pxl_valid, sof, eof, conv_reset, underrun, pxl_2, pxl_1, pxl_0};
            check_output($sformatf("%s_pix%0d", tag, i), 32'(act_v), 32'(exp_v));
            start = mid_start && (i == 3 || i == FRAME_LEN - 1);
            step();
            start = 1'b0;
        end
        check_output({tag, "_end"}, 32'({pxl_valid, conv_reset, busy, sof, eof}), 32'b01000);
    endtask

    initial begin
        logic [31:0] accepted;
        logic        seen;
        int          lvl, lo, hi;

        tbl[0] = '{preload: 12, pattern: 1'b1, mid_start: 1'b0, exp_underrun: 1'b0};
        tbl[1] = '{preload: 6,  pattern: 1'b1, mid_start: 1'b0, exp_underrun: 1'b1};
        tbl[2] = '{preload: 16, pattern: 1'b0, mid_start: 1'b1, exp_underrun: 1'b0};
        tbl[3] = '{preload: 8,  pattern: 1'b0, mid_start: 1'b0, exp_underrun: 1'b0};
        tbl[4] = '{preload: 4,  pattern: 1'b1, mid_start: 1'b1, exp_underrun: 1'b1};

        // Reset values while reset is held, then ready one clock after release.
        repeat (3) step();
        check_output("reset_outputs",
            32'({pxl_valid, sof, eof, conv_reset, busy, underrun, in_ready, pxl_2, pxl_1, pxl_0}),
            32'({7'b0001000, 24'd0}));
        @(negedge clk);
        reset = 1'b1;
        step();
        check_output("ready_after_release", 32'(in_ready), 32'd1);

        // Table-driven frames. The FIFO level carries over between rows.
        for (int v = 0; v < 5; v++) begin
            $display("[TB] table row %0d: preload %0d", v, tbl[v].preload);
            preload(tbl[v].preload, tbl[v].pattern);
            pulse_start($sformatf("row%0d", v));
            check_frame(tbl[v].mid_start, $sformatf("row%0d", v));
            check_output($sformatf("row%0d_underrun", v), 32'(underrun), 32'(tbl[v].exp_underrun));
        end

        // Hold in_valid in IDLE. The FIFO takes exactly FIFO_DEPTH pixels, and
        // ready returns with the first pop.
        accepted = 0;
        in_valid = 1'b1;
        in_data  = next_pattern();
        for (int t = 0; t < FIFO_DEPTH + 8; t++) begin
            seen = in_ready;
            step();
            if (seen) begin
                model_q.push_back(in_data);
                accepted++;
                in_data = next_pattern();
            end
        end
        in_valid = 1'b0;
        check_output("full_accepted", accepted, 32'(FIFO_DEPTH));
        check_output("full_ready_low", 32'(in_ready), 32'd0);
        pulse_start("full");
        check_frame(1'b0, "full");
        check_output("full_ready_before_sof", 32'(ready_before_sof), 32'd0);
        check_output("full_ready_at_sof", 32'(ready_at_sof), 32'd1);

        // Random preload amounts and data, checked against the queue model.
        for (int n = 0; n < 8; n++) begin
            lvl = model_q.size();
            lo  = (lvl >= START_LVL) ? 0 : START_LVL - lvl;
            hi  = FIFO_DEPTH - lvl;
            preload($urandom_range(hi, lo), 1'b0);
            pulse_start($sformatf("rnd%0d", n));
            check_frame(1'($urandom_range(1, 0)), $sformatf("rnd%0d", n));
        end

        // Reset at pixel 5 abandons the frame and flushes the FIFO.
        while (model_q.size() < 12) apply_stimulus(24'($urandom));
        pulse_start("rst");
        repeat (5) step();
        reset = 1'b0;
        #1;
        check_output("rst_outputs",
            32'({pxl_valid, sof, eof, conv_reset, busy, underrun, in_ready, pxl_2, pxl_1, pxl_0}),
            32'({7'b0001000, 24'd0}));
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_output("rst_ready", 32'(in_ready), 32'd1);
        preload(START_LVL - 1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            seen = seen | pxl_valid;
            step();
        end
        check_output("rst_fill_wait", 32'({seen, busy}), 32'b01);
        preload(1, 1'b1);
        check_frame(1'b0, "rst_refill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
